// File: rtl/pc_return_stack.sv
// Purpose: hardware return-address stack for a program counter (CALL pushes PC+1, RET pops).
// Latency: DIN/PC_LD are combinational from RET and the current top; LEVEL/flags update at the edge.
// Backpressure: none; illegal requests (overflow, underflow, collision) are dropped and flagged sticky.
module pc_return_stack #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [9:0]               PC_COUNT,
  input  logic                     CALL,
  input  logic                     RET,
  output logic [9:0]               DIN,
  output logic                     PC_LD,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVF,
  output logic                     UNF,
  output logic                     COLL
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Return-address storage; entries above the pointer are stale and never observed.
  logic [9:0]    mem [DEPTH];
  logic [LW-1:0] sp;
  logic          ovf_q;
  logic          unf_q;
  logic          coll_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  // Decode occupancy and the legal push/pop requests from the pointer.
  // When full the low pointer bits wrap to 0, so wr_idx-1 still lands on DEPTH-1 (the top).
  always_comb begin
    full    = (sp == LW'(DEPTH));
    empty   = (sp == '0);
    push    = CALL & ~RET & ~full;
    pop     = RET & ~CALL & ~empty;
    wr_idx  = sp[AW-1:0];
    top_idx = wr_idx - AW'(1);
  end

  // Write the return address (wraps 1023 -> 0) into the slot just above the top.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_idx] <= PC_COUNT + 10'd1;
    end
  end

  // Stack pointer and sticky error flags; reset overrides any request in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sp     <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      if (push) begin
        sp <= sp + LW'(1);
      end else if (pop) begin
        sp <= sp - LW'(1);
      end
      if (CALL && RET) begin
        coll_q <= 1'b1;
      end
      if (CALL && !RET && full) begin
        ovf_q <= 1'b1;
      end
      if (RET && !CALL && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  // Zero-latency return path so the PC can load the address on the same edge as RET.
  always_comb begin
    PC_LD = pop & ~RST;
    DIN   = (empty || RST) ? 10'd0 : mem[top_idx];
    LEVEL = sp;
    FULL  = full;
    EMPTY = empty;
    OVF   = ovf_q;
    UNF   = unf_q;
    COLL  = coll_q;
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: directed scenarios plus random traffic against a queue-based model.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Every comparison goes through check(); the summary prints passed/total.
module tb_pc_return_stack;

  localparam int DEPTH = 16;

  logic                   CLK;
  logic                   RST;
  logic [9:0]             PC_COUNT;
  logic                   CALL;
  logic                   RET;
  logic [9:0]             DIN;
  logic                   PC_LD;
  logic [$clog2(DEPTH):0] LEVEL;
  logic                   FULL;
  logic                   EMPTY;
  logic                   OVF;
  logic                   UNF;
  logic                   COLL;

  pc_return_stack #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC_COUNT(PC_COUNT), .CALL(CALL), .RET(RET),
    .DIN(DIN), .PC_LD(PC_LD), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY),
    .OVF(OVF), .UNF(UNF), .COLL(COLL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a plain queue of return addresses and three sticky bits.
  int stk[$];
  bit m_ovf, m_unf, m_coll;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply inputs on the falling edge and compare every output against the model.
  task automatic drive(input bit c, input bit r, input int pc, input bit rst);
    int exp_din;
    bit exp_ld;
    @(negedge CLK);
    CALL = c; RET = r; PC_COUNT = 10'(pc); RST = rst;
    #1;
    exp_ld  = r && !c && (stk.size() > 0) && !rst;
    exp_din = (rst || stk.size() == 0) ? 0 : stk[stk.size()-1];
    check("pc_ld", int'(PC_LD), int'(exp_ld));
    check("din",   int'(DIN),   exp_din);
    check("level", int'(LEVEL), stk.size());
    check("full",  int'(FULL),  int'(stk.size() == DEPTH));
    check("empty", int'(EMPTY), int'(stk.size() == 0));
    check("ovf",   int'(OVF),   int'(m_ovf));
    check("unf",   int'(UNF),   int'(m_unf));
    check("coll",  int'(COLL),  int'(m_coll));
  endtask

  // Rising edge, then advance the model by the rules of the stack.
  task automatic clk_edge();
    @(posedge CLK);
    if (RST) begin
      stk.delete();
      m_ovf = 0; m_unf = 0; m_coll = 0;
    end else if (CALL && RET) begin
      m_coll = 1;
    end else if (CALL) begin
      if (stk.size() == DEPTH) m_ovf = 1;
      else stk.push_back((int'(PC_COUNT) + 1) % 1024);
    end else if (RET) begin
      if (stk.size() == 0) m_unf = 1;
      else void'(stk.pop_back());
    end
  endtask

  task automatic cyc(input bit c, input bit r, input int pc, input bit rst);
    drive(c, r, pc, rst);
    clk_edge();
  endtask

  initial begin
    CALL = 0; RET = 0; PC_COUNT = '0; RST = 1;
    m_ovf = 0; m_unf = 0; m_coll = 0;

    // Reset state
    @(posedge CLK);
    cyc(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("rst_level", int'(LEVEL), 0);
    check("rst_empty", int'(EMPTY), 1);
    clk_edge();

    // Push/pop order
    cyc(1, 0, 21, 0);
    cyc(1, 0, 40, 0);
    cyc(1, 0, 100, 0);
    drive(0, 0, 0, 0); check("order_level", int'(LEVEL), 3); clk_edge();
    drive(0, 1, 0, 0); check("order_din0", int'(DIN), 101); check("order_ld0", int'(PC_LD), 1); clk_edge();
    drive(0, 1, 0, 0); check("order_din1", int'(DIN), 41);  clk_edge();
    drive(0, 1, 0, 0); check("order_din2", int'(DIN), 22);  clk_edge();
    drive(0, 0, 0, 0); check("order_empty", int'(EMPTY), 1); clk_edge();

    // Address wrap
    cyc(1, 0, 1023, 0);
    drive(0, 1, 0, 0); check("wrap_din", int'(DIN), 0); check("wrap_ld", int'(PC_LD), 1); clk_edge();

    // Full and overflow
    for (int i = 0; i < 16; i++) cyc(1, 0, i, 0);
    drive(0, 0, 0, 0); check("full_flag", int'(FULL), 1); check("full_level", int'(LEVEL), 16); clk_edge();
    cyc(1, 0, 500, 0);
    drive(0, 0, 0, 0); check("ovf_flag", int'(OVF), 1); check("ovf_level", int'(LEVEL), 16); clk_edge();
    drive(0, 1, 0, 0); check("ovf_din", int'(DIN), 16); clk_edge();

    // Underflow
    cyc(0, 0, 0, 1);
    drive(0, 1, 0, 0); check("unf_ld", int'(PC_LD), 0); check("unf_din", int'(DIN), 0); clk_edge();
    drive(0, 0, 0, 0); check("unf_flag", int'(UNF), 1); check("unf_level", int'(LEVEL), 0); clk_edge();
    cyc(1, 0, 5, 0);
    drive(0, 1, 0, 0); check("unf_din6", int'(DIN), 6); clk_edge();
    drive(0, 0, 0, 0); check("unf_sticky", int'(UNF), 1); clk_edge();

    // Collision
    cyc(0, 0, 0, 1);
    cyc(1, 0, 10, 0);
    cyc(1, 0, 20, 0);
    drive(1, 1, 300, 0); check("coll_ld", int'(PC_LD), 0); clk_edge();
    drive(0, 0, 0, 0); check("coll_level", int'(LEVEL), 2); check("coll_flag", int'(COLL), 1); clk_edge();
    drive(0, 1, 0, 0); check("coll_din", int'(DIN), 21); clk_edge();

    // Reset precedence over CALL with OVF set and LEVEL=3
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 200 + i, 0);
    cyc(1, 0, 77, 0);
    for (int i = 0; i < 13; i++) cyc(0, 1, 0, 0);
    drive(0, 0, 0, 0); check("prec_level3", int'(LEVEL), 3); check("prec_ovf1", int'(OVF), 1); clk_edge();
    drive(1, 0, 7, 1); check("prec_ld", int'(PC_LD), 0); check("prec_din", int'(DIN), 0); clk_edge();
    drive(0, 0, 0, 0);
    check("prec_level", int'(LEVEL), 0); check("prec_empty", int'(EMPTY), 1);
    check("prec_ovf", int'(OVF), 0); check("prec_unf", int'(UNF), 0); check("prec_coll", int'(COLL), 0);
    clk_edge();

    // Random traffic: biased toward push/pop, rare collisions and resets, idle holds mixed in.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      bit c, r, rs;
      sel = $urandom_range(0, 99);
      rs  = (sel == 0);
      c   = (sel >= 1 && sel < 48) || (sel >= 90 && sel < 94);
      r   = (sel >= 48 && sel < 80) || (sel >= 90 && sel < 94);
      cyc(c, r, $urandom_range(0, 1023), rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
